// File: rtl/mc_pkg.sv
// Shared types for the multicycle controller: FSM states, opcodes, immediate/writeback codes
// and the decoded-instruction record carried from DECODE to the later states.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WBACK  = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] WB_RAM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [2:0] {
    CL_ILLEGAL,
    CL_R,
    CL_I,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL
  } op_class_t;

  typedef struct packed {
    op_class_t  op_class;
    logic       alu_src;
    logic [1:0] imm_sel;
    logic [1:0] wb_sel;
  } dec_t;

  // Decode of an unrecognised opcode (including the all-zero reset opcode).
  localparam dec_t DEC_NONE = '{op_class: CL_ILLEGAL, alu_src: 1'b0, imm_sel: IMM_I, wb_sel: WB_RAM};

  function automatic logic is_mem(input op_class_t c);
    return (c == CL_LOAD) || (c == CL_STORE);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode decoder: class, ALU B-source, immediate format, writeback source, legality.
// JAL is recognised only when SUPPORT_JAL is set; anything else decodes as illegal.
module mc_decode
  import mc_pkg::*;
#(
  parameter bit SUPPORT_JAL = 1'b1
) (
  input  logic [6:0] opcode,
  output dec_t       dec,
  output logic       legal
);

  always_comb begin
    dec = DEC_NONE;
    case (opcode)
      OP_R: begin
        dec.op_class = CL_R;
        dec.alu_src  = 1'b0;
        dec.wb_sel   = WB_ALU;
      end
      OP_I: begin
        dec.op_class = CL_I;
        dec.alu_src  = 1'b1;
        dec.imm_sel  = IMM_I;
        dec.wb_sel   = WB_ALU;
      end
      OP_LOAD: begin
        dec.op_class = CL_LOAD;
        dec.alu_src  = 1'b1;
        dec.imm_sel  = IMM_I;
        dec.wb_sel   = WB_RAM;
      end
      OP_STORE: begin
        dec.op_class = CL_STORE;
        dec.alu_src  = 1'b1;
        dec.imm_sel  = IMM_S;
      end
      OP_BRANCH: begin
        dec.op_class = CL_BRANCH;
        dec.alu_src  = 1'b0;
        dec.imm_sel  = IMM_B;
      end
      OP_JAL: begin
        if (SUPPORT_JAL) begin
          dec.op_class = CL_JAL;
          dec.imm_sel  = IMM_J;
          dec.wb_sel   = WB_PC4;
        end
      end
      default: dec = DEC_NONE;
    endcase
    legal = (dec.op_class != CL_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WBACK with a sticky TRAP state.
// Zero-wait latency R/I/JAL/store 4, load 5, branch 3 cycles; memory waits bounded by MEM_TIMEOUT.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter bit SUPPORT_JAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] OPCode,
  input  logic       Zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCsrc,
  output logic       EnW,
  output logic       ALUsrc,
  output logic       RAMWrite,
  output logic       RAMRead,
  output logic [1:0] IMMSelect,
  output logic [1:0] WB,
  output logic       illegal,
  output logic [2:0] state
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     cur_state;
  state_t     nxt_state;
  logic [7:0] wait_cnt;
  logic       illegal_q;
  dec_t       dec_q;
  dec_t       dec_in;
  logic       in_legal;
  logic       waiting;
  logic       timeout;

  mc_decode #(
    .SUPPORT_JAL(SUPPORT_JAL)
  ) u_decode (
    .opcode(OPCode),
    .dec   (dec_in),
    .legal (in_legal)
  );

  assign waiting = (cur_state == S_FETCH) || (cur_state == S_MEM);
  assign timeout = (wait_cnt == WAIT_LAST);

  // A ready seen in the final wait cycle takes priority over the timeout.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_FETCH: begin
        if (imem_ready)   nxt_state = S_DECODE;
        else if (timeout) nxt_state = S_TRAP;
      end
      S_DECODE: nxt_state = in_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (dec_q.op_class)
          CL_R, CL_I, CL_JAL: nxt_state = S_WBACK;
          CL_LOAD, CL_STORE:  nxt_state = S_MEM;
          CL_BRANCH:          nxt_state = S_FETCH;
          default:            nxt_state = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (!is_mem(dec_q.op_class)) nxt_state = S_TRAP;
        else if (dmem_ready)         nxt_state = (dec_q.op_class == CL_LOAD) ? S_WBACK : S_FETCH;
        else if (timeout)            nxt_state = S_TRAP;
      end
      S_WBACK: nxt_state = S_FETCH;
      S_TRAP:  nxt_state = S_TRAP;
      default: nxt_state = S_TRAP;
    endcase
  end

  // The latched opcode is kept in decoded form; DEC_NONE is the decode of opcode 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_FETCH;
      wait_cnt  <= 8'd0;
      dec_q     <= DEC_NONE;
      illegal_q <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (nxt_state != cur_state) wait_cnt <= 8'd0;
      else if (waiting)           wait_cnt <= wait_cnt + 8'd1;
      if (cur_state == S_DECODE) dec_q <= dec_in;
      if (nxt_state == S_TRAP)   illegal_q <= 1'b1;
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCsrc     = 1'b0;
    EnW       = 1'b0;
    RAMWrite  = 1'b0;
    RAMRead   = 1'b0;
    ALUsrc    = dec_q.alu_src;
    IMMSelect = dec_q.imm_sel;
    WB        = dec_q.wb_sel;
    case (cur_state)
      S_FETCH: begin
        imem_req = 1'b1;
        IRWrite  = imem_ready;
        PCWrite  = imem_ready;
      end
      S_EXEC: begin
        if (dec_q.op_class == CL_BRANCH) begin
          PCsrc   = Zero;
          PCWrite = Zero;
        end else if (dec_q.op_class == CL_JAL) begin
          PCsrc   = 1'b1;
          PCWrite = 1'b1;
        end
      end
      S_MEM: begin
        RAMRead  = (dec_q.op_class == CL_LOAD);
        RAMWrite = (dec_q.op_class == CL_STORE);
      end
      S_WBACK: EnW = 1'b1;
      default: ;
    endcase
    // Reset forces FETCH asynchronously; keep its request and load enables quiet meanwhile.
    if (!rst_n) begin
      imem_req = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      EnW      = 1'b0;
      RAMRead  = 1'b0;
      RAMWrite = 1'b0;
    end
  end

  assign illegal = illegal_q;
  assign state   = cur_state;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max wait cycles per memory handshake before trap; range 1..255.
REQ-002 Parameter SUPPORT_JAL, default 1: 1 = decode JAL (7'b1101111); 0 = JAL treated as illegal.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 OPCode  input  7  instruction opcode from instruction register; valid from DECODE onward.
REQ-006 Zero  input  1  ALU zero flag; sampled only in EXEC.
REQ-007 imem_ready  input  1  instruction memory handshake completion.
REQ-008 dmem_ready  input  1  data memory handshake completion.
REQ-009 imem_req  output  1  instruction fetch request.
REQ-010 IRWrite, PCWrite, PCsrc, EnW, ALUsrc, RAMWrite, RAMRead  outputs  1 each  IR load, PC load, PC source (0 = PC+4, 1 = target), regfile write, ALU B = immediate, data write, data read.
REQ-011 IMMSelect  output  2  00 I-type, 01 S-type, 10 B-type, 11 J-type.
REQ-012 WB  output  2  writeback source: 00 RAM data, 01 ALU result, 10 PC+4.
REQ-013 illegal  output  1  sticky trap flag.
REQ-014 state  output  3  current FSM state, for debug.

Function
REQ-015 FSM states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WBACK=4, TRAP=5; codes 6-7 SHALL go to TRAP on the next edge.
REQ-016 Outputs SHALL be combinational from state, latched opcode and Zero; every output not listed as asserted in a state SHALL be 0, except IMMSelect/ALUsrc/WB, which SHALL hold the decode of the latched opcode.
REQ-017 FETCH: imem_req=1; stay while imem_ready=0; when imem_ready=1, IRWrite=1, PCWrite=1, PCsrc=0, go to DECODE.
REQ-018 DECODE: latch OPCode internally. Next state is EXEC for 0110011, 0010011, 0000011, 0100011 and 1100011, and for 1101111 when SUPPORT_JAL=1; any other opcode goes to TRAP.
REQ-019 Decode table: R 0110011: ALUsrc=0, WB=01. I 0010011: ALUsrc=1, IMMSel=00, WB=01. Load 0000011: ALUsrc=1, IMMSel=00, WB=00. Store 0100011: ALUsrc=1, IMMSel=01. Branch 1100011: ALUsrc=0, IMMSel=10. JAL: IMMSel=11, WB=10.
REQ-020 EXEC: R/I go to WBACK; load/store go to MEM; branch asserts PCsrc=Zero and PCWrite=Zero, then goes to FETCH; JAL asserts PCsrc=1 and PCWrite=1, then goes to WBACK.
REQ-021 MEM: load asserts RAMRead=1 and store asserts RAMWrite=1 until dmem_ready=1; then load goes to WBACK and store goes to FETCH.
REQ-022 Wait counter, 8 bits: cleared on every state change; increments each cycle spent waiting in FETCH or MEM; if it reaches MEM_TIMEOUT while ready is still low, go to TRAP. A ready arriving in that same cycle SHALL win.
REQ-023 WBACK: EnW=1 for exactly one cycle, then go to FETCH.
REQ-024 TRAP: illegal=1; all enables 0; remain in TRAP until reset.
REQ-025 Latency with zero-wait memory: R/I/JAL 4 cycles; load 5; store 4; branch 3.
REQ-026 EnW, RAMWrite and PCWrite SHALL never be asserted outside the states listed above.

Reset
REQ-027 rst_n low SHALL immediately force state=FETCH, wait counter=0, latched opcode=0 and illegal=0, regardless of the current state, including mid-handshake.
REQ-028 While rst_n is low, imem_req, IRWrite, PCWrite, EnW, RAMRead and RAMWrite SHALL be 0.
REQ-029 The first imem_req SHALL occur in the first cycle after rst_n deasserts.

Structure
REQ-030 Shared package mc_pkg SHALL hold the state enum, opcode constants, IMMSelect codes and WB codes.
REQ-031 Opcode decode SHALL be a combinational sub-module mc_decode (opcode -> class, ALUsrc, IMMSelect, WB, legal); the FSM instantiates it.

Verification
REQ-032 R-type 0110011, imem_ready and dmem_ready tied to 1 -> states 0,1,2,4,0; EnW=1 only in cycle 4; WB=01.
REQ-033 Load 0000011, dmem_ready rising 3 cycles after MEM entry -> RAMRead=1 for 4 cycles, then WBACK with WB=00 and EnW pulse; total 8 cycles.
REQ-034 Branch 1100011: with Zero=1 -> PCWrite=1 and PCsrc=1 in EXEC; with Zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
REQ-035 Store with dmem_ready held 0 and MEM_TIMEOUT=15 -> TRAP after 15 wait cycles, illegal=1 sticky; rst_n pulse -> FETCH, illegal=0.
REQ-036 Opcode 1101111 with SUPPORT_JAL=0 -> TRAP from DECODE; with SUPPORT_JAL=1 -> PCsrc=1 and PCWrite=1 in EXEC, then WBACK with WB=10.
REQ-037 rst_n asserted mid-MEM with RAMWrite=1 -> RAMWrite drops to 0 without waiting for a clock edge; state=0.
